// File: rtl/lf_pkg.sv
// Shared types and prefix-cell helpers for the Ladner-Fischer adder slice.
package lf_pkg;

  localparam int unsigned WIDTH_DEF = 32;
  localparam int unsigned NGRP_DEF  = WIDTH_DEF / 2;

  typedef struct packed {
    logic p;
    logic g;
  } pg_t;

  // Full prefix cell: combines a high and a low (p, g) pair.
  function automatic pg_t pg_black(input logic p_hi, input logic g_hi,
                                   input logic p_lo, input logic g_lo);
    pg_t r;
    r.p = p_hi & p_lo;
    r.g = g_hi | (p_hi & g_lo);
    return r;
  endfunction

  // Generate-only cell, used where the group propagate is no longer needed.
  function automatic logic pg_grey(input logic p_hi, input logic g_hi, input logic g_lo);
    return g_hi | (p_hi & g_lo);
  endfunction

endpackage

// File: rtl/lf_level1_comb.sv
// Level-1 pairwise prefix combine; group 0 folds the carry-in so its propagate is 0.
module lf_level1_comb
  import lf_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0]   p,
  input  logic [WIDTH-1:0]   g,
  input  logic               cin,
  output logic [WIDTH/2-1:0] p_list1,
  output logic [WIDTH/2-1:0] g_list1
);

  localparam int unsigned NGRP = WIDTH / 2;

  assign p_list1[0] = 1'b0;
  assign g_list1[0] = pg_grey(p[1], g[1], pg_grey(p[0], g[0], cin));

  for (genvar i = 1; i < NGRP; i++) begin : g_grp
    pg_t c;
    assign c          = pg_black(p[2*i+1], g[2*i+1], p[2*i], g[2*i]);
    assign p_list1[i] = c.p;
    assign g_list1[i] = c.g;
  end

endmodule

// File: rtl/lf_pg_front.sv
// Two-stage valid/ready front end: operand capture, bitwise p/g, level-1 combine.
module lf_pg_front
  import lf_pkg::*;
#(
  parameter int unsigned WIDTH       = WIDTH_DEF,
  parameter bit          STALL_CLEAR = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               cin,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH/2-1:0] p_list1,
  output logic [WIDTH/2-1:0] g_list1,
  output logic [WIDTH-1:0]   p_bit,
  output logic               cin_q
);

  localparam int unsigned NGRP = WIDTH / 2;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic             s1_cin;

  logic [WIDTH-1:0] s1_p;
  logic [WIDTH-1:0] s1_g;
  logic [NGRP-1:0]  l1_p;
  logic [NGRP-1:0]  l1_g;

  logic s2_free;
  logic accept;
  logic drain;

  // in_ready is combinational from out_ready; there is no skid buffer.
  assign s2_free  = ~out_valid | out_ready;
  assign in_ready = ~s1_valid | s2_free;
  assign accept   = in_valid & in_ready;
  assign drain    = s1_valid & s2_free;

  assign s1_p = s1_a ^ s1_b;
  assign s1_g = s1_a & s1_b;

  lf_level1_comb #(
    .WIDTH (WIDTH)
  ) u_level1 (
    .p       (s1_p),
    .g       (s1_g),
    .cin     (s1_cin),
    .p_list1 (l1_p),
    .g_list1 (l1_g)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_cin   <= 1'b0;
    end else begin
      if (accept) begin
        s1_a   <= a;
        s1_b   <= b;
        s1_cin <= cin;
      end
      if (accept) begin
        s1_valid <= 1'b1;
      end else if (drain) begin
        s1_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      p_list1   <= '0;
      g_list1   <= '0;
      p_bit     <= '0;
      cin_q     <= 1'b0;
    end else if (drain) begin
      out_valid <= 1'b1;
      p_list1   <= l1_p;
      g_list1   <= l1_g;
      p_bit     <= s1_p;
      cin_q     <= s1_cin;
    end else if (out_ready) begin
      out_valid <= 1'b0;
      if (STALL_CLEAR) begin
        p_list1 <= '0;
        g_list1 <= '0;
        p_bit   <= '0;
        cin_q   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lf_pg_front.sv
// Directed self-checking bench for lf_pg_front.
module tb_lf_pg_front;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        cin = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] p_list1;
  logic [15:0] g_list1;
  logic [31:0] p_bit;
  logic        cin_q;

  int checks   = 0;
  int failures = 0;

  // Hand-computed beats: operands and expected level-1 results.
  logic [31:0] sa  [8] = '{32'h0000000F, 32'h0000000F, 32'h00000001, 32'h00000003,
                           32'h0000000C, 32'hAAAAAAAA, 32'hF0000000, 32'h00010000};
  logic [31:0] sb  [8] = '{32'h00000000, 32'h0000000F, 32'h00000000, 32'h00000000,
                           32'h00000004, 32'h55555555, 32'h30000000, 32'h00030000};
  logic        sc  [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
  logic [15:0] spl [8] = '{16'h0002, 16'h0000, 16'h0000, 16'h0000,
                           16'h0000, 16'hFFFE, 16'h8000, 16'h0000};
  logic [15:0] sgl [8] = '{16'h0000, 16'h0003, 16'h0000, 16'h0001,
                           16'h0002, 16'h0000, 16'h4000, 16'h0100};
  logic [31:0] spb [8] = '{32'h0000000F, 32'h00000000, 32'h00000001, 32'h00000003,
                           32'h00000008, 32'hFFFFFFFF, 32'hC0000000, 32'h00020000};

  lf_pg_front #(
    .WIDTH       (32),
    .STALL_CLEAR (1'b0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p_list1   (p_list1),
    .g_list1   (g_list1),
    .p_bit     (p_bit),
    .cin_q     (cin_q)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] ta, input logic [31:0] tb, input logic tc,
                       input logic v);
    a        = ta;
    b        = tb;
    cin      = tc;
    in_valid = v;
  endtask

  task automatic check_out(input string tag, input logic [15:0] epl, input logic [15:0] egl,
                           input logic [31:0] epb, input logic ecin);
    check({tag, ".valid"}, 32'(out_valid), 32'h1);
    check({tag, ".p_list1"}, 32'(p_list1), 32'(epl));
    check({tag, ".g_list1"}, 32'(g_list1), 32'(egl));
    check({tag, ".p_bit"}, p_bit, epb);
    check({tag, ".cin_q"}, 32'(cin_q), 32'(ecin));
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".valid"}, 32'(out_valid), 32'h0);
    check({tag, ".p_list1"}, 32'(p_list1), 32'h0);
    check({tag, ".g_list1"}, 32'(g_list1), 32'h0);
    check({tag, ".p_bit"}, p_bit, 32'h0);
    check({tag, ".cin_q"}, 32'(cin_q), 32'h0);
  endtask

  // One isolated beat with out_ready=1: latency 2, then valid drops and payload holds.
  task automatic single(input string tag, input logic [31:0] ta, input logic [31:0] tb,
                        input logic tc, input logic [15:0] epl, input logic [15:0] egl,
                        input logic [31:0] epb);
    @(posedge clk); #1;
    drive(ta, tb, tc, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check({tag, ".lat1"}, 32'(out_valid), 32'h0);
    @(negedge clk);
    check_out(tag, epl, egl, epb, tc);
    @(negedge clk);
    check({tag, ".drop"}, 32'(out_valid), 32'h0);
    check({tag, ".hold"}, p_bit, epb);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    #1;
    check("reset.in_ready", 32'(in_ready), 32'h1);

    single("t1", 32'h00000003, 32'h00000001, 1'b0, 16'h0000, 16'h0001, 32'h00000002);
    single("t2", 32'hFFFFFFFF, 32'h00000000, 1'b1, 16'hFFFE, 16'h0001, 32'hFFFFFFFF);
    single("t3", 32'h80000000, 32'h80000000, 1'b0, 16'h0000, 16'h8000, 32'h00000000);

    // Back-to-back stream: beat c is visible two cycles after it is offered.
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (c < 8) drive(sa[c], sb[c], sc[c], 1'b1);
      else in_valid = 1'b0;
      @(negedge clk);
      if (c < 8) check($sformatf("stream%0d.in_ready", c), 32'(in_ready), 32'h1);
      if (c >= 2) begin
        check_out($sformatf("stream%0d", c - 2), spl[c-2], sgl[c-2], spb[c-2], sc[c-2]);
      end else begin
        check($sformatf("stream%0d.empty", c), 32'(out_valid), 32'h0);
      end
    end
    @(negedge clk);
    check("stream.tail", 32'(out_valid), 32'h0);

    // Stall: beat 5 reaches S2, beat 6 waits in S1, beat 7 is offered but refused.
    @(posedge clk); #1;
    out_ready = 1'b0;
    drive(sa[5], sb[5], sc[5], 1'b1);
    @(posedge clk); #1;
    check("stall.in_ready_s1", 32'(in_ready), 32'h1);
    drive(sa[6], sb[6], sc[6], 1'b1);
    @(posedge clk); #1;
    drive(sa[7], sb[7], sc[7], 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_out($sformatf("stall%0d", i), spl[5], sgl[5], spb[5], sc[5]);
      check($sformatf("stall%0d.in_ready", i), 32'(in_ready), 32'h0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    @(negedge clk);
    check_out("release.b5", spl[5], sgl[5], spb[5], sc[5]);
    check("release.in_ready", 32'(in_ready), 32'h1);
    @(negedge clk);
    check_out("release.b6", spl[6], sgl[6], spb[6], sc[6]);
    @(negedge clk);
    check("release.empty", 32'(out_valid), 32'h0);

    // Reset with two beats in flight.
    @(posedge clk); #1;
    out_ready = 1'b0;
    drive(sa[7], sb[7], sc[7], 1'b1);
    @(posedge clk); #1;
    drive(sa[6], sb[6], sc[6], 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check_out("inflight.b7", spl[7], sgl[7], spb[7], sc[7]);
    rst = 1'b1;
    #1;
    check_zero("midreset");
    @(negedge clk);
    rst       = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("postreset%0d.valid", i), 32'(out_valid), 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
